// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath with one shared memory port.
// Latency: R/I-type 4, LW 5, SW 4, branch 3, jump 3 cycles with zero-wait memory.
// Backpressure: memory states hold until mem_ready, trapping after MEM_WAIT_MAX idle cycles.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 8,
  parameter int WAIT_W       = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_cond_n,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       jal_link,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [5:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       trap
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_TRAP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_FUNCT = 6'b000010;

  state_t            state_q;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic [WAIT_W:0]   wait_inc;
  logic              wait_state;
  logic              wait_expired;
  logic [5:0]        alu_op_imm;

  assign state = state_q;

  // Only the three memory-facing states can stall on mem_ready.
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                      (state_q == S_MEM_WRITE);

  // One extra bit so the limit compare cannot alias on wrap.
  assign wait_inc     = {1'b0, wait_cnt} + (WAIT_W+1)'(1);
  assign wait_expired = (MEM_WAIT_MAX != 0) && wait_state && !mem_ready &&
                        (wait_inc == (WAIT_W+1)'(MEM_WAIT_MAX));

  // ADDI uses a plain add; the other immediate ops hand their opcode to the ALU decoder.
  assign alu_op_imm = (opcode == OP_ADDI) ? ALU_ADD : opcode;

  // Next-state selection.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)         state_nxt = S_DECODE;
        else if (wait_expired) state_nxt = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                               state_nxt = S_MEM_ADDR;
          OP_RTYPE:                                   state_nxt = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI, OP_SLTIU: state_nxt = S_EXEC_I;
          OP_BEQ, OP_BNE:                             state_nxt = S_BRANCH;
          OP_J, OP_JAL:                               state_nxt = S_JUMP;
          default:                                    state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_nxt = S_MEM_READ;
        else if (opcode == OP_SW) state_nxt = S_MEM_WRITE;
        else                      state_nxt = S_TRAP;
      end
      S_MEM_READ: begin
        if (mem_ready)         state_nxt = S_MEM_WB;
        else if (wait_expired) state_nxt = S_TRAP;
      end
      S_MEM_WB: state_nxt = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready)         state_nxt = S_FETCH;
        else if (wait_expired) state_nxt = S_TRAP;
      end
      S_EXEC_R: state_nxt = S_ALU_WB;
      S_EXEC_I: state_nxt = S_ALU_WB;
      S_ALU_WB: state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_TRAP;
    endcase
  end

  // Any state change clears the stall counter, so each memory state starts from zero.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (state_nxt != state_q)          wait_cnt_nxt = '0;
    else if (wait_state && !mem_ready) wait_cnt_nxt = wait_inc[WAIT_W-1:0];
  end

  // State and stall counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Datapath controls decoded from state; everything is held low during reset.
  always_comb begin
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    pc_write_cond_n = 1'b0;
    i_or_d          = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    mem_to_reg      = 1'b0;
    jal_link        = 1'b0;
    reg_dst         = 2'd0;
    reg_write       = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'd0;
    alu_op          = ALU_ADD;
    pc_source       = 2'd0;
    trap            = 1'b0;
    if (nrst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = alu_op_imm;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          if (opcode == OP_RTYPE) begin
            reg_dst = 2'd1;
            alu_op  = ALU_FUNCT;
          end else begin
            alu_op  = alu_op_imm;
          end
        end
        S_BRANCH: begin
          alu_src_a       = 1'b1;
          alu_op          = ALU_SUB;
          pc_source       = 2'd1;
          pc_write_cond   = (opcode == OP_BEQ);
          pc_write_cond_n = (opcode == OP_BNE);
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
          if (opcode == OP_JAL) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
            jal_link  = 1'b1;
          end
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: begin
          trap = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Drives inputs 1ns after the rising edge and samples 2ns after it.
// Each test applies its own reset so trap states never leak between tests.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       nrst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_write_cond_n, i_or_d;
  logic       mem_read, mem_write, ir_write, mem_to_reg, jal_link;
  logic [1:0] reg_dst;
  logic       reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic [5:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       trap;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_MAX(8), .WAIT_W(4)) dut (
    .clk(clk), .nrst(nrst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_cond_n(pc_write_cond_n),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .jal_link(jal_link), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .trap(trap)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    nrst      = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    next_cycle();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; mem_ready = 1'b1; opcode = 6'b101011;
    #2;
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if ({mem_read, ir_write, pc_write, alu_src_b} !== 5'b0) begin failures++;
      $display("FAIL rst_outputs got=%b exp=00000", {mem_read, ir_write, pc_write, alu_src_b}); end
    next_cycle();
    nrst = 1'b1;
    #1;
    checks++; if ({state, mem_read, ir_write} !== {4'd0, 2'b11}) begin failures++;
      $display("FAIL rst_fetch got=%0d/%b%b exp=0/11", state, mem_read, ir_write); end
    next_cycle(); next_cycle(); next_cycle();
    mem_ready = 1'b0;
    #1;
    checks++; if ({state, mem_write, i_or_d} !== {4'd5, 2'b11}) begin failures++;
      $display("FAIL sw_memwrite got=%0d/%b%b exp=5/11", state, mem_write, i_or_d); end
    nrst = 1'b0;
    #1;
    checks++; if ({state, mem_write, mem_read} !== {4'd0, 2'b00}) begin failures++;
      $display("FAIL rst_abort got=%0d/%b%b exp=0/00", state, mem_write, mem_read); end
    next_cycle();
    nrst = 1'b1;
    #1;
    checks++; if ({state, mem_read, i_or_d, alu_src_b, ir_write} !== {4'd0, 1'b1, 1'b0, 2'd1, 1'b0}) begin
      failures++; $display("FAIL rst_refetch got=%0d/%b%b%0d%b exp=0/1010", state, mem_read, i_or_d, alu_src_b, ir_write); end
  endtask

  task automatic test_rtype();
    int exp_st[5];
    exp_st = '{0, 1, 6, 7, 0};
    apply_reset();
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (state !== 4'(exp_st[i])) begin failures++;
        $display("FAIL rtype_seq[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      if (i == 2) begin
        checks++; if ({alu_src_a, alu_src_b, alu_op} !== {1'b1, 2'd0, 6'b000010}) begin failures++;
          $display("FAIL rtype_exec got=%b%0d/%b exp=1 0/000010", alu_src_a, alu_src_b, alu_op); end
      end
      if (i == 3) begin
        checks++; if ({reg_write, reg_dst, alu_op, mem_to_reg} !== {1'b1, 2'd1, 6'b000010, 1'b0}) begin failures++;
          $display("FAIL rtype_wb got=%b/%0d/%b/%b exp=1/1/000010/0", reg_write, reg_dst, alu_op, mem_to_reg); end
      end
      next_cycle();
    end
  endtask

  task automatic test_lw_wait();
    int exp_st[9];
    exp_st = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    apply_reset();
    opcode = 6'b100011;
    for (int i = 0; i < 9; i++) begin
      mem_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      #1;
      checks++; if (state !== 4'(exp_st[i])) begin failures++;
        $display("FAIL lw_seq[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      checks++; if ({reg_write, mem_to_reg} !== {2{exp_st[i] == 4}}) begin failures++;
        $display("FAIL lw_wb[%0d] got=%b%b exp=%b", i, reg_write, mem_to_reg, {2{exp_st[i] == 4}}); end
      if (exp_st[i] == 3) begin
        checks++; if ({mem_read, i_or_d} !== 2'b11) begin failures++;
          $display("FAIL lw_memread[%0d] got=%b%b exp=11", i, mem_read, i_or_d); end
      end
      next_cycle();
    end
  endtask

  task automatic test_ori();
    apply_reset();
    opcode = 6'b001101; mem_ready = 1'b1;
    next_cycle(); next_cycle();
    #1;
    checks++; if ({state, alu_op, alu_src_a, alu_src_b} !== {4'd8, 6'b001101, 1'b1, 2'd2}) begin failures++;
      $display("FAIL ori_exec got=%0d/%b/%b%0d exp=8/001101/1 2", state, alu_op, alu_src_a, alu_src_b); end
    next_cycle();
    #1;
    checks++; if ({state, reg_write, reg_dst, alu_op} !== {4'd7, 1'b1, 2'd0, 6'b001101}) begin failures++;
      $display("FAIL ori_wb got=%0d/%b/%0d/%b exp=7/1/0/001101", state, reg_write, reg_dst, alu_op); end
    next_cycle();
    #1;
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL ori_done got=%0d exp=0", state); end
  endtask

  task automatic test_addi();
    apply_reset();
    opcode = 6'b001000; mem_ready = 1'b1;
    next_cycle(); next_cycle();
    #1;
    checks++; if ({state, alu_op} !== {4'd8, 6'b000000}) begin failures++;
      $display("FAIL addi_exec got=%0d/%b exp=8/000000", state, alu_op); end
  endtask

  task automatic test_branch();
    apply_reset();
    opcode = 6'b000101; mem_ready = 1'b1;
    next_cycle(); next_cycle();
    #1;
    checks++; if ({state, pc_write_cond_n, pc_write_cond, alu_op, pc_source, pc_write} !==
                  {4'd9, 1'b1, 1'b0, 6'b000001, 2'd1, 1'b0}) begin failures++;
      $display("FAIL bne_branch got=%0d/%b%b/%b/%0d/%b exp=9/10/000001/1/0",
               state, pc_write_cond_n, pc_write_cond, alu_op, pc_source, pc_write); end
    next_cycle();
    #1;
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL bne_done got=%0d exp=0", state); end
    opcode = 6'b000100;
    next_cycle(); next_cycle();
    #1;
    checks++; if ({state, pc_write_cond, pc_write_cond_n} !== {4'd9, 2'b10}) begin failures++;
      $display("FAIL beq_branch got=%0d/%b%b exp=9/10", state, pc_write_cond, pc_write_cond_n); end
  endtask

  task automatic test_jump();
    apply_reset();
    opcode = 6'b000011; mem_ready = 1'b1;
    next_cycle(); next_cycle();
    #1;
    checks++; if ({state, pc_write, pc_source, reg_write, reg_dst, jal_link} !==
                  {4'd10, 1'b1, 2'd2, 1'b1, 2'd2, 1'b1}) begin failures++;
      $display("FAIL jal_jump got=%0d/%b/%0d/%b/%0d/%b exp=10/1/2/1/2/1",
               state, pc_write, pc_source, reg_write, reg_dst, jal_link); end
    next_cycle();
    opcode = 6'b000010;
    next_cycle(); next_cycle();
    #1;
    checks++; if ({state, pc_write, pc_source, reg_write, jal_link} !== {4'd10, 1'b1, 2'd2, 1'b0, 1'b0}) begin
      failures++; $display("FAIL j_jump got=%0d/%b/%0d/%b/%b exp=10/1/2/0/0",
                           state, pc_write, pc_source, reg_write, jal_link); end
  endtask

  task automatic test_bad_opcode();
    apply_reset();
    opcode = 6'b111111; mem_ready = 1'b1;
    next_cycle(); next_cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({state, trap, mem_read, pc_write} !== {4'd11, 1'b1, 2'b00}) begin failures++;
        $display("FAIL bad_op_trap[%0d] got=%0d/%b/%b%b exp=11/1/00", i, state, trap, mem_read, pc_write); end
      next_cycle();
    end
  endtask

  task automatic test_fetch_timeout();
    apply_reset();
    opcode = 6'b000000; mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if ({state, trap} !== {4'd0, 1'b0}) begin failures++;
        $display("FAIL timeout_wait[%0d] got=%0d/%b exp=0/0", i, state, trap); end
      next_cycle();
    end
    #1;
    checks++; if ({state, trap} !== {4'd11, 1'b1}) begin failures++;
      $display("FAIL timeout_trap got=%0d/%b exp=11/1", state, trap); end
    mem_ready = 1'b1;
    next_cycle();
    #1;
    checks++; if ({state, trap} !== {4'd11, 1'b1}) begin failures++;
      $display("FAIL timeout_sticky got=%0d/%b exp=11/1", state, trap); end
  endtask

  task automatic test_ready_at_limit();
    apply_reset();
    opcode = 6'b000000; mem_ready = 1'b0;
    for (int i = 0; i < 7; i++) next_cycle();
    mem_ready = 1'b1;
    #1;
    checks++; if ({state, ir_write, trap} !== {4'd0, 1'b1, 1'b0}) begin failures++;
      $display("FAIL limit_ready got=%0d/%b/%b exp=0/1/0", state, ir_write, trap); end
    next_cycle();
    #1;
    checks++; if ({state, trap} !== {4'd1, 1'b0}) begin failures++;
      $display("FAIL limit_decode got=%0d/%b exp=1/0", state, trap); end
  endtask

  initial begin
    nrst = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_ori();
    test_addi();
    test_branch();
    test_jump();
    test_bad_opcode();
    test_fetch_timeout();
    test_ready_at_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS control FSM. Sequences a shared-memory multi-cycle datapath (PC, IR, register file, ALU, single memory port) across FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps.
- Consumes the IR opcode and a memory ready handshake.
- Emits per-cycle datapath enables and mux selects, plus a sticky trap flag.
- Supported opcodes: R-type, ADDI, ORI, ANDI, SLTI, SLTIU, LW, SW, BEQ, BNE, J, JAL.

Parameters:
- MEM_WAIT_MAX, 8: max cycles a memory state waits for mem_ready before trapping. 0 disables the timeout.
- WAIT_W, 4: width of the wait counter. Must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until next FETCH completes
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (BEQ)
- pc_write_cond_n  out  1  PC load if ALU not zero (BNE)
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  write-back data: 0=ALUOut, 1=MDR
- jal_link  out  1  write-back data = PC (overrides mem_to_reg)
- reg_dst  out  2  destination register: 0=rt, 1=rd, 2=$ra
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A: 0=PC, 1=A reg
- alu_src_b  out  2  ALU B: 0=B reg, 1=constant 4, 2=sign-extended imm, 3=sign-extended imm<<2
- alu_op  out  6  000000=add, 000001=sub, 000010=R-type funct; ORI/ANDI/SLTI/SLTIU pass their opcode through
- pc_source  out  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target
- state  out  4  current state (debug)
- trap  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is asynchronous and active-low.
- On reset: state=FETCH(0), wait counter=0, trap=0. While nrst=0, every output is 0 except state.
- Outputs are Moore-style, decoded from state. Exceptions: opcode qualifies outputs in EXEC_I, ALU_WB, BRANCH and JUMP; mem_ready gates pc_write and ir_write in FETCH.
- Any output not listed for a state is 0.
- FETCH (0):
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, add, pc_source=0.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE. Otherwise stay.
- DECODE (1): alu_src_a=0, alu_src_b=3, add. Next state by opcode:
  - LW, SW -> MEM_ADDR
  - R-type -> EXEC_R
  - ADDI, ORI, ANDI, SLTI, SLTIU -> EXEC_I
  - BEQ, BNE -> BRANCH
  - J, JAL -> JUMP
  - any other opcode -> TRAP
- MEM_ADDR (2): alu_src_a=1, alu_src_b=2, add. LW -> MEM_READ; SW -> MEM_WRITE.
- MEM_READ (3): mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
- MEM_WB (4): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE (5): mem_write=1, i_or_d=1. Waits for mem_ready, then FETCH.
- EXEC_R (6): alu_src_a=1, alu_src_b=0, alu_op=000010 -> ALU_WB.
- EXEC_I (8): alu_src_a=1, alu_src_b=2. alu_op=000000 for ADDI, otherwise opcode -> ALU_WB.
- ALU_WB (7): reg_write=1, mem_to_reg=0. reg_dst=1 for R-type, 0 otherwise. Holds the EXEC alu_op. -> FETCH.
- BRANCH (9): alu_src_a=1, alu_src_b=0, alu_op=000001, pc_source=1. BEQ asserts pc_write_cond; BNE asserts pc_write_cond_n. -> FETCH.
- JUMP (10): pc_write=1, pc_source=2. For JAL also reg_write=1, reg_dst=2, jal_link=1. -> FETCH.
- TRAP (11): trap=1, all other outputs 0. Sticky until nrst.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle spent in those states with mem_ready=0.
  - If it reaches MEM_WAIT_MAX while mem_ready=0 (and MEM_WAIT_MAX≠0) -> TRAP.
  - mem_ready=1 in the same cycle the limit is hit wins; no trap.
- Latency: R/I-type = 4 cycles; LW = 5; SW = 4; branch = 3; jump = 3. All assume zero-wait memory.
- Reset mid-instruction aborts immediately to FETCH with outputs at 0. No partial write persists beyond the current cycle.
- States 12–15 are unreachable; if entered, go to TRAP.

Test Plan:
- Reset: nrst=0 mid-MEM_WRITE -> state=0, mem_write=0 within the same cycle; after nrst=1, mem_read=1 in FETCH.
- R-type with mem_ready tied 1 -> sequence 0,1,6,7,0. In state 7: reg_write=1, reg_dst=1, alu_op=000010.
- LW with mem_ready low 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4.
- ORI -> EXEC_I with alu_op=001101, ALU_WB with reg_dst=0. BNE -> BRANCH with pc_write_cond_n=1, pc_write_cond=0, alu_op=000001.
- JAL -> JUMP with pc_write=1, pc_source=2, reg_write=1, reg_dst=2, jal_link=1. J -> same state but reg_write=0.
- opcode=111111 -> TRAP after DECODE, trap=1 held. mem_ready stuck 0 in FETCH with MEM_WAIT_MAX=8 -> TRAP after 8 cycles.
